spi_shift_reg: RTL

//  Master-side SPI data path; sits directly downstream of the slave-select generator.
//  - Loads the APB transmit byte and drives it serially on MOSI on SCLK edges.
//  - Assembles MISO bits into a receive word.
//  - Hands the received word to the APB data register when the slave-select stage

---
 rtl/spi_shift_reg_if.sv | 32 +++
 rtl/spi_shift_reg.sv | 97 +++++++++
 2 files changed

// File: rtl/spi_shift_reg_if.sv
// Bundle of the SPI data-path control, strobe and data signals between the
// slave-select/APB side (master modport) and the shift register (slave modport).
interface spi_shift_reg_if #(
  parameter int unsigned DATA_W = 8
);
  logic              mstr_i;
  logic              spiswai_i;
  logic              cpha_i;
  logic              lsbfe_i;
  logic              ss_i;
  logic              send_data_i;
  logic [DATA_W-1:0] data_mosi_i;
  logic              sclk_lead_i;
  logic              sclk_trail_i;
  logic              miso_i;
  logic              receive_data_i;
  logic              mosi_o;
  logic [DATA_W-1:0] data_miso_o;
  logic              shift_done_o;

  modport master (
    output mstr_i, spiswai_i, cpha_i, lsbfe_i, ss_i, send_data_i, data_mosi_i,
    output sclk_lead_i, sclk_trail_i, miso_i, receive_data_i,
    input  mosi_o, data_miso_o, shift_done_o
  );

  modport slave (
    input  mstr_i, spiswai_i, cpha_i, lsbfe_i, ss_i, send_data_i, data_mosi_i,
    input  sclk_lead_i, sclk_trail_i, miso_i, receive_data_i,
    output mosi_o, data_miso_o, shift_done_o
  );
endinterface

// File: rtl/spi_shift_reg.sv
// Master-side SPI shift register: serialises the transmit word on MOSI and assembles MISO.
// Define SPI_SHIFT_LOOPBACK_EN to sample mosi_o instead of miso_i (internal loopback).
module spi_shift_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input logic            PCLK,
  input logic            PRESET_n,
  spi_shift_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] data_miso_q, data_miso_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              mosi_q, mosi_d;
  logic              shift_done_q, shift_done_d;

  logic enabled, active, load, lead, trail, sample, shift, sample_bit;

  always_comb begin
    enabled = bus.mstr_i & ~bus.spiswai_i;
    active  = enabled & ~bus.ss_i;
    load    = enabled & bus.send_data_i;
    lead    = active & bus.sclk_lead_i;
    // Simultaneous lead and trail is a protocol error; the trail is dropped.
    trail   = active & bus.sclk_trail_i & ~bus.sclk_lead_i;
    sample  = (bus.cpha_i ? trail : lead) && (bit_cnt_q < FullCnt);
    shift   = bus.cpha_i ? lead : trail;
`ifdef SPI_SHIFT_LOOPBACK_EN
    sample_bit = mosi_q;
`else
    sample_bit = bus.miso_i;
`endif
  end

  always_comb begin
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    data_miso_d  = data_miso_q;
    bit_cnt_d    = bit_cnt_q;
    mosi_d       = mosi_q;
    shift_done_d = 1'b0;
    if (load) begin
      tx_sr_d   = bus.data_mosi_i;
      rx_sr_d   = '0;
      bit_cnt_d = '0;
      mosi_d    = bus.lsbfe_i ? bus.data_mosi_i[0] : bus.data_mosi_i[DATA_W-1];
    end else begin
      // No advance before the first sample (CPHA=1 first lead re-drives bit 0) or after the last.
      if (shift && (bit_cnt_q != '0) && (bit_cnt_q < FullCnt)) begin
        if (bus.lsbfe_i) begin
          tx_sr_d = tx_sr_q >> 1;
          mosi_d  = tx_sr_q[1];
        end else begin
          tx_sr_d = tx_sr_q << 1;
          mosi_d  = tx_sr_q[DATA_W-2];
        end
      end
      if (sample) begin
        rx_sr_d      = bus.lsbfe_i ? {sample_bit, rx_sr_q[DATA_W-1:1]}
                                   : {rx_sr_q[DATA_W-2:0], sample_bit};
        bit_cnt_d    = bit_cnt_q + CNT_W'(1);
        shift_done_d = (bit_cnt_q == LastCnt);
      end
      if (bus.receive_data_i) begin
        data_miso_d = rx_sr_d;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      data_miso_q  <= '0;
      bit_cnt_q    <= '0;
      mosi_q       <= 1'b0;
      shift_done_q <= 1'b0;
    end else begin
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      data_miso_q  <= data_miso_d;
      bit_cnt_q    <= bit_cnt_d;
      mosi_q       <= mosi_d;
      shift_done_q <= shift_done_d;
    end
  end

  assign bus.mosi_o       = mosi_q;
  assign bus.data_miso_o  = data_miso_q;
  assign bus.shift_done_o = shift_done_q;

endmodule
